// File: rtl/wave_pkg.sv
// wave_pkg: shared definitions for the waveform-generator sequencer.
//   - state_t   : sequencer states (IDLE, LOAD, RUN, DONE)
//   - FUNC_*    : function-select codes understood by the datapath
//   - DIV_W, NCYC_W, CNT_W : default widths of prescaler, period limit and
//                            datapath sample counter
package wave_pkg;

  localparam int DIV_W  = 8;
  localparam int NCYC_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Function-select codes; FUNC_DDS routes the DDS output to the wave core.
  localparam logic [2:0] FUNC_SQUARE = 3'b000;
  localparam logic [2:0] FUNC_SAW    = 3'b001;
  localparam logic [2:0] FUNC_TRI    = 3'b010;
  localparam logic [2:0] FUNC_SINE   = 3'b011;
  localparam logic [2:0] FUNC_DDS    = 3'b110;

endpackage

// File: rtl/wave_gen_ctrl_if.sv
// wave_gen_ctrl_if: user/board control bus and datapath control outputs of
// the waveform-generator sequencer.
//   master : user side  -- drives start/stop and the cfg_* bus, observes status
//   slave  : sequencer  -- consumes controls, drives ld_reg/inc_cnt/sel_func/
//            phase_cntrl/sample_vld/busy/done/period_cnt
interface wave_gen_ctrl_if #(
  parameter int DIV_W  = 8,
  parameter int NCYC_W = 8
);
  logic              start;
  logic              stop;
  logic              cfg_we;
  logic [2:0]        cfg_func;
  logic [1:0]        cfg_phase;
  logic [DIV_W-1:0]  cfg_div;
  logic [NCYC_W-1:0] cfg_ncyc;

  logic              ld_reg;
  logic              inc_cnt;
  logic [2:0]        sel_func;
  logic [1:0]        phase_cntrl;
  logic              sample_vld;
  logic              busy;
  logic              done;
  logic [NCYC_W-1:0] period_cnt;

  modport master (
    output start, stop, cfg_we, cfg_func, cfg_phase, cfg_div, cfg_ncyc,
    input  ld_reg, inc_cnt, sel_func, phase_cntrl, sample_vld, busy, done,
           period_cnt
  );

  modport slave (
    input  start, stop, cfg_we, cfg_func, cfg_phase, cfg_div, cfg_ncyc,
    output ld_reg, inc_cnt, sel_func, phase_cntrl, sample_vld, busy, done,
           period_cnt
  );
endinterface

// File: rtl/wave_prescaler.sv
// wave_prescaler: loadable down-counter pacing the sample counter.
//   clk, rst  : clock, synchronous active-low reset
//   en        : count down; at 0 reload with load_val instead
//   load      : force-load load_val (wins over en)
//   load_val  : reload value
//   tick      : counter currently reads 0
//   zero_nxt  : counter will read 0 next cycle (lets the owner register
//               its increment strobe so it lines up with tick)
module wave_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick,
  output logic         zero_nxt
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_nxt_s;

  // Next count value: load, count down with reload at 0, or hold.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (load) begin
      cnt_nxt_s = load_val;
    end else if (en) begin
      if (cnt_r == '0) begin
        cnt_nxt_s = load_val;
      end else begin
        cnt_nxt_s = cnt_r - W'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign tick     = (cnt_r == '0);
  assign zero_nxt = (cnt_nxt_s == '0);

endmodule

// File: rtl/wave_gen_ctrl.sv
// wave_gen_ctrl: sequencer for the waveform-generator datapath.
//   clk, rst : clock, synchronous active-low reset
//   bus      : wave_gen_ctrl_if.slave -- start/stop, cfg_* capture bus, and the
//              registered datapath controls ld_reg, inc_cnt, sel_func,
//              phase_cntrl plus status sample_vld, busy, done, period_cnt.
// Outputs are Moore-registered: each output register is loaded from the
// next state, so ld_reg/busy/done/inc_cnt are high exactly in the cycles the
// state register holds LOAD / LOAD-or-RUN / DONE / RUN-with-prescaler-at-0.
module wave_gen_ctrl #(
  parameter int DIV_W  = wave_pkg::DIV_W,
  parameter int NCYC_W = wave_pkg::NCYC_W,
  parameter int CNT_W  = wave_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  wave_gen_ctrl_if.slave   bus
);
  import wave_pkg::*;

  function automatic logic [NCYC_W-1:0] sat_inc(input logic [NCYC_W-1:0] v);
    if (v == {NCYC_W{1'b1}}) begin
      return v;
    end else begin
      return v + NCYC_W'(1);
    end
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;

  logic [2:0]        pend_func_r;
  logic [1:0]        pend_phase_r;
  logic [DIV_W-1:0]  pend_div_r;
  logic [NCYC_W-1:0] pend_ncyc_r;
  logic              pend_flag_r;

  logic [2:0]        sel_func_r;
  logic [1:0]        phase_r;
  logic [DIV_W-1:0]  div_r;
  logic [NCYC_W-1:0] ncyc_r;

  logic [CNT_W-1:0]  idx_r;
  logic [NCYC_W-1:0] period_r;
  logic [NCYC_W-1:0] period_inc_s;

  logic              ld_reg_r;
  logic              inc_cnt_r;
  logic              sample_vld_r;
  logic              busy_r;
  logic              done_r;

  logic              load_exit_s;
  logic              run_go_s;
  logic              step_s;
  logic              wrap_s;
  logic              run_start_s;
  logic              tick_s;
  logic              zero_nxt_s;
  logic [DIV_W-1:0]  presc_val_s;

  // LOAD copies the pending divider; in RUN the prescaler reloads the active one.
  assign load_exit_s  = (state_r == ST_LOAD) && !bus.stop;
  assign run_go_s     = (state_r == ST_RUN)  && !bus.stop;
  assign step_s       = run_go_s && tick_s;
  assign wrap_s       = step_s && (idx_r == {CNT_W{1'b1}});
  assign run_start_s  = (state_r == ST_IDLE) && (state_nxt_s == ST_LOAD);
  assign period_inc_s = sat_inc(period_r);
  assign presc_val_s  = load_exit_s ? pend_div_r : div_r;

  wave_prescaler #(.W(DIV_W)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .en       (run_go_s),
    .load     (load_exit_s),
    .load_val (presc_val_s),
    .tick     (tick_s),
    .zero_nxt (zero_nxt_s)
  );

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (bus.stop) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_nxt_s = ST_IDLE;
        end else if (wrap_s) begin
          if ((ncyc_r != '0) && (period_inc_s == ncyc_r)) begin
            state_nxt_s = ST_DONE;
          end else if (pend_flag_r) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state and registered strobes/status derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      ld_reg_r     <= 1'b0;
      inc_cnt_r    <= 1'b0;
      sample_vld_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      ld_reg_r     <= (state_nxt_s == ST_LOAD);
      inc_cnt_r    <= (state_nxt_s == ST_RUN) && zero_nxt_s;
      sample_vld_r <= inc_cnt_r;
      busy_r       <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_RUN);
      done_r       <= (state_nxt_s == ST_DONE);
    end
  end

  // Pending/active configuration. A write during LOAD lands in pending after
  // the copy, so pend_flag stays set and the write is applied at the next wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_func_r  <= 3'b000;
      pend_phase_r <= 2'b00;
      pend_div_r   <= '0;
      pend_ncyc_r  <= '0;
      pend_flag_r  <= 1'b0;
      sel_func_r   <= 3'b000;
      phase_r      <= 2'b00;
      div_r        <= '0;
      ncyc_r       <= '0;
    end else begin
      if (load_exit_s) begin
        sel_func_r <= pend_func_r;
        phase_r    <= pend_phase_r;
        div_r      <= pend_div_r;
        ncyc_r     <= pend_ncyc_r;
      end
      if (bus.cfg_we) begin
        pend_func_r  <= bus.cfg_func;
        pend_phase_r <= bus.cfg_phase;
        pend_div_r   <= bus.cfg_div;
        pend_ncyc_r  <= bus.cfg_ncyc;
        pend_flag_r  <= 1'b1;
      end else if (load_exit_s) begin
        pend_flag_r  <= 1'b0;
      end
    end
  end

  // Sample index and completed-period counter; cleared only when a run starts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_r    <= '0;
      period_r <= '0;
    end else if (run_start_s) begin
      idx_r    <= '0;
      period_r <= '0;
    end else if (step_s) begin
      idx_r <= idx_r + CNT_W'(1);
      if (wrap_s) begin
        period_r <= period_inc_s;
      end
    end
  end

  assign bus.ld_reg      = ld_reg_r;
  assign bus.inc_cnt     = inc_cnt_r;
  assign bus.sel_func    = sel_func_r;
  assign bus.phase_cntrl = phase_r;
  assign bus.sample_vld  = sample_vld_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.period_cnt  = period_r;

endmodule
